// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWaitI = 2'd1,
        StWaitD = 2'd2
    } arb_state_e;

    typedef enum logic {
        OwnI = 1'b0,
        OwnD = 1'b1
    } owner_e;

    localparam int unsigned MAX_WAIT_DEFAULT = 3;

    function automatic int unsigned wait_cnt_w(input int unsigned max_wait);
        return $clog2(max_wait + 1);
    endfunction

    localparam int unsigned WAIT_CNT_W = $clog2(MAX_WAIT_DEFAULT + 1);

endpackage

// File: rtl/mem_arb_sel.sv
// Owner selection for the shared memory port: data wins unless fetch has lost
// MAX_WAIT consecutive grants while pending.
module mem_arb_sel
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic d_req,
    input  logic i_gnt,
    input  logic d_gnt,
    output logic o_sel
);

    localparam int unsigned            CNT_W   = wait_cnt_w(MAX_WAIT);
    localparam logic [CNT_W-1:0]       CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_i_forced;
    owner_e           w_sel;

    assign w_i_forced = (r_wait_cnt == CNT_MAX);

    always_comb begin
        w_sel = OwnD;
        if (i_req && (!d_req || w_i_forced)) begin
            w_sel = OwnI;
        end
    end

    assign o_sel = w_sel;

    // Counts D grants taken while fetch was waiting; saturates at CNT_MAX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (i_gnt) begin
            r_wait_cnt <= '0;
        end else if (d_gnt && i_req && !w_i_forced) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch (I) and load/store (D) requesters onto one single-port memory,
// one outstanding access at a time. Optional counters: define MEM_ARB_PERF_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]         perf_i_gnt,
    output logic [31:0]         perf_d_gnt,
    output logic [31:0]         perf_conflict
`endif
);

    arb_state_e r_state;
    arb_state_e w_state_next;
    logic       w_sel_bit;
    owner_e     w_sel;

    mem_arb_sel #(
        .MAX_WAIT (MAX_WAIT)
    ) u_sel (
        .clk    (clk),
        .reset  (reset),
        .i_req  (i_req),
        .d_req  (d_req),
        .i_gnt  (i_gnt),
        .d_gnt  (d_gnt),
        .o_sel  (w_sel_bit)
    );

    assign w_sel = owner_e'(w_sel_bit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (i_gnt) begin
                    w_state_next = StWaitI;
                end else if (d_gnt) begin
                    w_state_next = StWaitD;
                end
            end
            StWaitI, StWaitD: begin
                if (mem_rvalid) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Everything is forced low during reset, so a late response is never forwarded.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        i_rvalid  = 1'b0;
        i_rdata   = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        if (!reset) begin
            case (r_state)
                StIdle: begin
                    mem_req = i_req | d_req;
                    if (w_sel == OwnI) begin
                        mem_addr = i_addr;
                        mem_be   = '1;
                    end else begin
                        mem_we    = d_we;
                        mem_addr  = d_addr;
                        mem_wdata = d_wdata;
                        mem_be    = d_be;
                    end
                    i_gnt = mem_req & mem_ready & (w_sel == OwnI);
                    d_gnt = mem_req & mem_ready & (w_sel == OwnD);
                end
                StWaitI: begin
                    i_rvalid = mem_rvalid;
                    i_rdata  = mem_rdata;
                end
                StWaitD: begin
                    d_rvalid = mem_rvalid;
                    d_rdata  = mem_rdata;
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_perf_i_gnt;
    logic [31:0] r_perf_d_gnt;
    logic [31:0] r_perf_conflict;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_i_gnt    <= '0;
            r_perf_d_gnt    <= '0;
            r_perf_conflict <= '0;
        end else begin
            if (i_gnt && r_perf_i_gnt != '1) begin
                r_perf_i_gnt <= r_perf_i_gnt + 32'd1;
            end
            if (d_gnt && r_perf_d_gnt != '1) begin
                r_perf_d_gnt <= r_perf_d_gnt + 32'd1;
            end
            if ((r_state == StIdle) && i_req && d_req && r_perf_conflict != '1) begin
                r_perf_conflict <= r_perf_conflict + 32'd1;
            end
        end
    end

    assign perf_i_gnt    = r_perf_i_gnt;
    assign perf_d_gnt    = r_perf_d_gnt;
    assign perf_conflict = r_perf_conflict;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a per-cycle reference model.
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 3;
    localparam int BE_W     = DATA_W / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]       perf_i_gnt;
    logic [31:0]       perf_d_gnt;
    logic [31:0]       perf_conflict;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_gnt      (i_gnt),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_be       (d_be),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_i_gnt    (perf_i_gnt),
        .perf_d_gnt    (perf_d_gnt),
        .perf_conflict (perf_conflict)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the memory (0 none, 1 fetch, 2 data) and how many
    // grants a waiting fetch has lost in a row.
    int    m_busy = 0;
    int    m_loss = 0;
    bit    e_iw;
    bit    e_ig;
    bit    e_dg;
    bit    exp_gnt_any = 1'b0;
    string glog = "";
`ifdef MEM_ARB_PERF_EN
    logic [31:0] m_pi = '0;
    logic [31:0] m_pd = '0;
    logic [31:0] m_pc = '0;
`endif

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_mem_req", mem_req, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_mem_be", mem_be, 0);
            chk("rst_i_gnt", i_gnt, 0);
            chk("rst_d_gnt", d_gnt, 0);
            chk("rst_i_rvalid", i_rvalid, 0);
            chk("rst_d_rvalid", d_rvalid, 0);
            chk("rst_i_rdata", i_rdata, 0);
            chk("rst_d_rdata", d_rdata, 0);
`ifdef MEM_ARB_PERF_EN
            chk("rst_perf_i", perf_i_gnt, 0);
            chk("rst_perf_d", perf_d_gnt, 0);
            chk("rst_perf_c", perf_conflict, 0);
            m_pi = '0;
            m_pd = '0;
            m_pc = '0;
`endif
            m_busy      = 0;
            m_loss      = 0;
            exp_gnt_any = 1'b0;
        end else begin
`ifdef MEM_ARB_PERF_EN
            chk("perf_i_gnt", perf_i_gnt, m_pi);
            chk("perf_d_gnt", perf_d_gnt, m_pd);
            chk("perf_conflict", perf_conflict, m_pc);
`endif
            if (m_busy == 0) begin
                e_iw = i_req && (!d_req || m_loss >= MAX_WAIT);
                e_ig = e_iw && mem_ready;
                e_dg = d_req && !e_iw && mem_ready;
                chk("mem_req", mem_req, i_req | d_req);
                chk("i_gnt", i_gnt, e_ig);
                chk("d_gnt", d_gnt, e_dg);
                chk("idle_i_rvalid", i_rvalid, 0);
                chk("idle_d_rvalid", d_rvalid, 0);
                if (e_iw) begin
                    chk("i_mem_addr", mem_addr, i_addr);
                    chk("i_mem_we", mem_we, 0);
                    chk("i_mem_be", mem_be, 4'hF);
                end else if (d_req) begin
                    chk("d_mem_addr", mem_addr, d_addr);
                    chk("d_mem_we", mem_we, d_we);
                    chk("d_mem_wdata", mem_wdata, d_wdata);
                    chk("d_mem_be", mem_be, d_be);
                end
`ifdef MEM_ARB_PERF_EN
                if (i_req && d_req) m_pc = m_pc + 1;
                if (e_ig) m_pi = m_pi + 1;
                if (e_dg) m_pd = m_pd + 1;
`endif
                if (i_gnt) glog = {glog, "I"};
                if (d_gnt) glog = {glog, "D"};
                if (e_ig) begin
                    m_busy = 1;
                    m_loss = 0;
                end else if (e_dg) begin
                    m_busy = 2;
                    if (i_req && m_loss < MAX_WAIT) m_loss = m_loss + 1;
                end
                exp_gnt_any = e_ig | e_dg;
            end else begin
                chk("wait_mem_req", mem_req, 0);
                chk("wait_i_gnt", i_gnt, 0);
                chk("wait_d_gnt", d_gnt, 0);
                chk("wait_i_rvalid", i_rvalid, (m_busy == 1) && mem_rvalid);
                chk("wait_d_rvalid", d_rvalid, (m_busy == 2) && mem_rvalid);
                if (mem_rvalid && m_busy == 1) chk("i_rdata", i_rdata, mem_rdata);
                if (mem_rvalid && m_busy == 2) chk("d_rdata", d_rdata, mem_rdata);
                if (mem_rvalid) m_busy = 0;
                exp_gnt_any = 1'b0;
            end
        end
    end

    bit auto_resp = 1'b0;

    // Advance one clock; in auto mode the memory answers the cycle after a grant.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (auto_resp) begin
            mem_rvalid = exp_gnt_any;
            mem_rdata  = $urandom;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_be = '0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = '0;
        repeat (2) cycle();
        reset = 1'b0;
        cycle();

        // Fetch only.
        i_req = 1'b1; i_addr = 32'h100; mem_ready = 1'b1;
        @(negedge clk);
        chk("fetch_gnt", i_gnt, 1);
        chk("fetch_be", mem_be, 4'hF);
        chk("fetch_we", mem_we, 0);
        chk("fetch_addr", mem_addr, 32'h100);
        cycle();
        i_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
        @(negedge clk);
        chk("fetch_rvalid", i_rvalid, 1);
        chk("fetch_rdata", i_rdata, 32'h0050_0093);
        chk("fetch_d_rvalid", d_rvalid, 0);
        cycle();
        // Stray response while idle must not be forwarded.
        @(negedge clk);
        chk("stray_i_rvalid", i_rvalid, 0);
        chk("stray_d_rvalid", d_rvalid, 0);
        cycle();

        // Store.
        mem_rvalid = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'h3;
        @(negedge clk);
        chk("store_gnt", d_gnt, 1);
        chk("store_we", mem_we, 1);
        chk("store_addr", mem_addr, 32'h2000);
        chk("store_be", mem_be, 4'h3);
        chk("store_wdata", mem_wdata, 32'hDEAD_BEEF);
        cycle();
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("store_wait_rvalid", d_rvalid, 0);
        cycle();
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        chk("store_ack", d_rvalid, 1);
        chk("store_i_rvalid", i_rvalid, 0);
        cycle();
        mem_rvalid = 1'b0;

        // Contention with instant responses.
        auto_resp = 1'b1; glog = "";
        i_req = 1'b1; i_addr = 32'h108; d_req = 1'b1; d_addr = 32'h2004; d_wdata = 32'h1;
        d_be = 4'hF;
        repeat (16) cycle();
        i_req = 1'b0; d_req = 1'b0; auto_resp = 1'b0;
        @(negedge clk);
        n_checks++;
        if (glog == "DDDIDDDI") n_pass++;
        else $display("FAIL grant_order: got %s, expected DDDIDDDI", glog);
        cycle();

        // Backpressure.
        d_req = 1'b1; d_addr = 32'h3000; mem_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("bp_no_gnt", d_gnt, 0);
            chk("bp_mem_req", mem_req, 1);
            chk("bp_addr", mem_addr, 32'h3000);
            cycle();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("bp_gnt", d_gnt, 1);
        cycle();
        d_req = 1'b0;

        // Reset while waiting on the load.
        cycle();
        reset = 1'b1; i_req = 1'b1;
        @(negedge clk);
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_i_gnt", i_gnt, 0);
        chk("midrst_d_rvalid", d_rvalid, 0);
        cycle();
        cycle();
        reset = 1'b0; i_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("late_d_rvalid", d_rvalid, 0);
        chk("late_i_rvalid", i_rvalid, 0);
        cycle();
        mem_rvalid = 1'b0; i_req = 1'b1; i_addr = 32'h104;
        @(negedge clk);
        chk("post_rst_gnt", i_gnt, 1);
        cycle();
        i_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("post_rst_rvalid", i_rvalid, 1);
        chk("post_rst_rdata", i_rdata, 32'h1234_5678);
        cycle();
        mem_rvalid = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch requester (I) and load/store requester (D).
- Sequences each access as request/grant followed by a response, with one outstanding transaction at a time.
- Data accesses have priority, and a starvation counter guarantees forward progress for fetch.
- Sits between the fetch/LSU front ends of the RISC-V core and the shared memory, replacing the separate instruction and data memory paths in the multi-cycle build.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- MAX_WAIT, 3, number of consecutive D grants a pending I request may lose before I is forced to win (must be >=1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request; held with i_addr stable until i_gnt
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch data valid
- i_rdata  out  DATA_W  fetch data
- d_req  in  1  data request; held with fields stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid, or store acknowledged
- d_rdata  out  DATA_W  load data (don't-care on store ack)
- mem_req  out  1  request to memory
- mem_we  out  1  write enable to memory
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  write data to memory
- mem_be  out  DATA_W/8  byte enables to memory (all ones for fetch)
- mem_ready  in  1  memory accepts mem_req this cycle
- mem_rvalid  in  1  memory response (read data or write ack)
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- States: IDLE, WAIT_I, WAIT_D. Reset state is IDLE with wait_cnt=0.
- All outputs are 0 while reset is asserted. mem_req is explicitly gated by reset.
- IDLE, owner selection:
  - sel = I if i_req & (!d_req | wait_cnt==MAX_WAIT).
  - Otherwise sel = D if d_req.
  - Otherwise there is no request.
- IDLE, memory drive: mem_req = i_req|d_req, driven combinationally. mem_* fields are muxed from sel. Fetch drives mem_we=0 and mem_be all ones.
- Grant: x_gnt = mem_req & mem_ready & (sel==x). On grant, next state is WAIT_I or WAIT_D. Without mem_ready, stay in IDLE and re-arbitrate next cycle; sel may change.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, on a D grant while i_req=1.
  - Clears on an I grant.
  - Unchanged otherwise.
- WAIT_x: mem_req=0 and both gnt=0. x_rvalid=mem_rvalid and x_rdata=mem_rdata, both combinational. On mem_rvalid, go to IDLE. The other port's rvalid stays 0.
- Latency: grant in cycle N. Earliest response in N+1 (mem_rvalid in the first WAIT cycle). Earliest next grant is the cycle after the response. Minimum 2 cycles per access.
- mem_rvalid in IDLE is ignored and never forwarded.
- Reset mid-transaction: returns to IDLE immediately. A late mem_rvalid from the aborted access is dropped.
- Requester changing fields before gnt is a protocol violation, behaviour undefined.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, adds three outputs, each 32 bits, saturating at all ones, reset to 0:
  - perf_i_gnt counts I grants.
  - perf_d_gnt counts D grants.
  - perf_conflict counts IDLE cycles with i_req&d_req both high.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum (IDLE, WAIT_I, WAIT_D)
  - owner encoding (OWN_I, OWN_D)
  - the derived constant WAIT_CNT_W = $clog2(MAX_WAIT+1)
- One natural sub-module, mem_arb_sel: the combinational owner select plus wait_cnt register. Muxing and FSM stay in the top.

Test Plan:
- Fetch only: i_req=1, i_addr=0x100, mem_ready=1, mem_rvalid next cycle with 0x00500093 -> i_gnt in cycle 0; i_rvalid=1 and i_rdata=0x00500093 in cycle 1; mem_be=0xF, mem_we=0.
- Store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=0x3 -> mem_we=1, mem_addr=0x2000, mem_be=0x3 in the grant cycle; d_rvalid on ack; i_rvalid stays 0.
- Contention, MAX_WAIT=3, i_req and d_req held high, instant responses -> grant order D,D,D,I,D,D,D,I; wait_cnt returns to 0 after each I grant.
- Backpressure: mem_ready=0 for 4 cycles with d_req=1 -> no gnt, state stays IDLE, mem_req=1 with stable fields; grant on the first cycle with mem_ready=1.
- Reset mid-op: assert reset in WAIT_D, then pulse mem_rvalid after release -> all outputs 0 during reset; d_rvalid and i_rvalid stay 0; next i_req is granted normally.
- MEM_ARB_PERF_EN: 5 I grants, 2 D grants, 3 conflict cycles -> perf_i_gnt=5, perf_d_gnt=2, perf_conflict=3; all 0 after reset.
